// File: rtl/channel_demux.sv
// Splits a channel-interleaved AXI-Stream into NUM_CH independent FWFT streams,
// one small FIFO per channel, and flags any break in the round-robin channel order.
module channel_demux #(
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 2,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     s_axis_aclk,
   input  logic                     s_axis_arst,
   input  logic [DATA_W-1:0]        s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [CH_W-1:0]          s_axis_tuser,
   output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
   output logic [NUM_CH-1:0]        m_axis_tvalid,
   input  logic [NUM_CH-1:0]        m_axis_tready,
   output logic                     seq_err,
   output logic [15:0]              seq_err_cnt,
   input  logic                     seq_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic signed [DATA_W-1:0] mem [NUM_CH][FIFO_DEPTH];
   logic [AW:0]              wr_ptr [NUM_CH];
   logic [AW:0]              rd_ptr [NUM_CH];
   logic [NUM_CH-1:0]        full;
   logic [NUM_CH-1:0]        empty;
   logic [NUM_CH-1:0]        push;
   logic [NUM_CH-1:0]        pop;
   logic                     accept;
   logic                     viol;
   logic [CH_W-1:0]          expected_ch;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // A full channel stalls the whole input, even if that channel pops this cycle.
   assign s_axis_tready = ~full[s_axis_tuser];
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign viol          = accept & (s_axis_tuser != expected_ch);
   assign m_axis_tvalid = ~empty;

   always_comb begin
      full         = '0;
      empty        = '0;
      push         = '0;
      pop          = '0;
      m_axis_tdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         empty[c] = (wr_ptr[c] == rd_ptr[c]);
         full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                    (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
         push[c]  = accept && (s_axis_tuser == CH_W'(c));
         pop[c]   = !empty[c] && m_axis_tready[c];
         m_axis_tdata[c*DATA_W +: DATA_W] = mem[c][rd_ptr[c][AW-1:0]];
      end
   end

   always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
      if (s_axis_arst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
         end
      end
   end

   // Sample storage carries no reset; stale entries are masked by empty.
   always_ff @(posedge s_axis_aclk) begin
      if (accept)
         mem[s_axis_tuser][wr_ptr[s_axis_tuser][AW-1:0]] <= $signed(s_axis_tdata);
   end

   // Clear and a same-cycle violation combine to a fresh count of one.
   always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
      if (s_axis_arst) begin
         expected_ch <= '0;
         seq_err     <= 1'b0;
         seq_err_cnt <= '0;
      end else begin
         if (accept)
            expected_ch <= s_axis_tuser + CH_W'(1);
         if (seq_clr) begin
            seq_err     <= viol;
            seq_err_cnt <= viol ? 16'd1 : 16'd0;
         end else if (viol) begin
            seq_err     <= 1'b1;
            seq_err_cnt <= sat_inc(seq_err_cnt);
         end
      end
   end

endmodule

// File: tb/tb_channel_demux.sv
// Directed bench for channel_demux: routing, back-pressure, order check,
// saturation and asynchronous reset, with hand-computed expectations.
module tb_channel_demux;

   logic         clk = 1'b0;
   logic         arst;
   logic [31:0]  s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [1:0]   s_axis_tuser;
   logic [127:0] m_axis_tdata;
   logic [3:0]   m_axis_tvalid;
   logic [3:0]   m_axis_tready;
   logic         seq_err;
   logic [15:0]  seq_err_cnt;
   logic         seq_clr;

   int checks = 0;
   int errors = 0;

   logic        cap1 = 1'b0;
   logic        cap2 = 1'b0;
   logic [31:0] q1[$];
   logic [31:0] q2[$];

   channel_demux #(.NUM_CH(4), .CH_W(2), .DATA_W(32), .FIFO_DEPTH(4)) dut (
      .s_axis_aclk  (clk),
      .s_axis_arst  (arst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tuser (s_axis_tuser),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .seq_err      (seq_err),
      .seq_err_cnt  (seq_err_cnt),
      .seq_clr      (seq_clr)
   );

   always #5 clk = ~clk;

   // Record every pop on channels 1 and 2 (handshake is stable at the falling edge).
   always @(negedge clk) begin
      if (cap1 && m_axis_tvalid[1] && m_axis_tready[1]) q1.push_back(m_axis_tdata[63:32]);
      if (cap2 && m_axis_tvalid[2] && m_axis_tready[2]) q2.push_back(m_axis_tdata[95:64]);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] ch, input logic [31:0] d);
      int w;
      s_axis_tvalid = 1'b1;
      s_axis_tuser  = ch;
      s_axis_tdata  = d;
      w = 0;
      @(negedge clk);
      while (!s_axis_tready && w < 64) begin
         w++;
         @(negedge clk);
      end
      if (w >= 64) chk("send_timeout", 64'(s_axis_tready), 64'd1);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   initial begin
      int w;
      arst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = '0;
      m_axis_tready = 4'hF; seq_clr = 1'b0;
      cyc(); cyc();
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
      chk("rst_seq_err", 64'(seq_err), 64'h0);
      chk("rst_cnt", 64'(seq_err_cnt), 64'h0);
      chk("rst_tready", 64'(s_axis_tready), 64'h1);
      arst = 1'b0;
      cyc();

      // 1) one sample per channel, each emerges for exactly one cycle
      for (int c = 0; c < 4; c++) begin
         send(2'(c), 32'(100 + c));
         chk($sformatf("t1_valid%0d", c), 64'(m_axis_tvalid), 64'(4'b0001 << c));
         chk($sformatf("t1_data%0d", c), 64'(m_axis_tdata[c*32 +: 32]), 64'(100 + c));
      end
      cyc();
      chk("t1_idle", 64'(m_axis_tvalid), 64'h0);
      chk("t1_seq_err", 64'(seq_err), 64'h0);

      // 2) ch2 blocked: its FIFO fills and stalls the input on the next ch2 sample
      cap2 = 1'b1;
      m_axis_tready = 4'b1011;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) send(2'(c), 32'(1000 + 10*r + c));
      send(2'd0, 32'd1040);
      send(2'd1, 32'd1041);
      s_axis_tvalid = 1'b1; s_axis_tuser = 2'd2; s_axis_tdata = 32'd1042;
      cyc();
      @(negedge clk);
      chk("t2_stall", 64'(s_axis_tready), 64'h0);
      chk("t2_valid", 64'(m_axis_tvalid), 64'b0100);
      cyc();
      m_axis_tready = 4'hF;
      w = 0;
      @(negedge clk);
      while (!s_axis_tready && w < 64) begin w++; @(negedge clk); end
      chk("t2_unstall", 64'(s_axis_tready), 64'h1);
      cyc();
      s_axis_tvalid = 1'b0;
      send(2'd3, 32'd1043);
      for (int c = 0; c < 4; c++) send(2'(c), 32'(1050 + c));
      repeat (8) cyc();
      cap2 = 1'b0;
      chk("t2_count", 64'(q2.size()), 64'd6);
      for (int r = 0; r < 6; r++)
         if (r < q2.size()) chk($sformatf("t2_order%0d", r), 64'(q2[r]), 64'(1000 + 10*r + 2));

      // 3) ch1 full: other channels keep draining; no push while full even with a pop
      cap1 = 1'b1;
      m_axis_tready = 4'b1101;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) send(2'(c), 32'(2000 + 10*r + c));
      send(2'd0, 32'd2040);
      s_axis_tvalid = 1'b1; s_axis_tuser = 2'd1; s_axis_tdata = 32'd2041;
      cyc();
      @(negedge clk);
      chk("t3_stall", 64'(s_axis_tready), 64'h0);
      chk("t3_drained", 64'(m_axis_tvalid), 64'b0010);
      cyc();
      m_axis_tready = 4'hF;
      @(negedge clk);
      chk("t3_full_pop", 64'(s_axis_tready), 64'h0);
      cyc();
      @(negedge clk);
      chk("t3_space", 64'(s_axis_tready), 64'h1);
      cyc();
      s_axis_tvalid = 1'b0;
      send(2'd2, 32'd2042);
      send(2'd3, 32'd2043);
      repeat (8) cyc();
      cap1 = 1'b0;
      chk("t3_count", 64'(q1.size()), 64'd5);
      for (int r = 0; r < 5; r++)
         if (r < q1.size()) chk($sformatf("t3_order%0d", r), 64'(q1[r]), 64'(2000 + 10*r + 1));
      chk("t3_seq_err", 64'(seq_err), 64'h0);

      // 4) order 0,1,3,0
      send(2'd0, 32'd300);
      send(2'd1, 32'd301);
      send(2'd3, 32'd303);
      chk("t4_err", 64'(seq_err), 64'h1);
      chk("t4_cnt", 64'(seq_err_cnt), 64'd1);
      send(2'd0, 32'd304);
      chk("t4_resync", 64'(seq_err_cnt), 64'd1);

      // 5) clear colliding with a violation, then saturation
      send(2'd2, 32'd305);
      chk("t5_cnt2", 64'(seq_err_cnt), 64'd2);
      seq_clr = 1'b1;
      send(2'd0, 32'd306);
      seq_clr = 1'b0;
      chk("t5_clr_err", 64'(seq_err), 64'h1);
      chk("t5_clr_cnt", 64'(seq_err_cnt), 64'd1);
      seq_clr = 1'b1;
      cyc();
      seq_clr = 1'b0;
      chk("t5_clr_only_err", 64'(seq_err), 64'h0);
      chk("t5_clr_only_cnt", 64'(seq_err_cnt), 64'd0);
      for (int i = 0; i < 65535; i++) send(2'd0, 32'(i));
      chk("t5_sat", 64'(seq_err_cnt), 64'hFFFF);
      send(2'd0, 32'd7);
      chk("t5_sat_hold", 64'(seq_err_cnt), 64'hFFFF);
      chk("t5_sat_err", 64'(seq_err), 64'h1);

      // 6) asynchronous reset with three samples buffered on ch0
      seq_clr = 1'b1; cyc(); seq_clr = 1'b0;
      m_axis_tready = 4'b1110;
      send(2'd0, 32'd500);
      send(2'd0, 32'd501);
      send(2'd0, 32'd502);
      chk("t6_buffered", 64'(m_axis_tvalid), 64'b0001);
      #2 arst = 1'b1;
      #1;
      chk("t6_async_valid", 64'(m_axis_tvalid), 64'h0);
      @(negedge clk); #1;
      arst = 1'b0;
      m_axis_tready = 4'hF;
      cyc();
      s_axis_tvalid = 1'b1; s_axis_tuser = 2'd0; s_axis_tdata = 32'd777;
      @(negedge clk);
      chk("t6_pre_accept", 64'(m_axis_tvalid), 64'h0);
      cyc();
      s_axis_tvalid = 1'b0;
      chk("t6_valid", 64'(m_axis_tvalid), 64'b0001);
      chk("t6_data", 64'(m_axis_tdata[31:0]), 64'd777);
      chk("t6_seq_err", 64'(seq_err), 64'h0);
      cyc();
      chk("t6_drained", 64'(m_axis_tvalid), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
